// File: rtl/nibble_serial_adder_if.sv
// Handshake and data bundle between the operand source, nibble_serial_adder and the result consumer.
// The master side drives operands and out_ready; the slave side is the adder itself.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit carry-lookahead slice reused per nibble, LSB nibble first,
// with the inter-nibble carry held in a register and valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic [CNT_W-1:0] nib_cnt;

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] s4;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  // Lookahead slice: every carry is a flat sum of generate/propagate products, no ripple.
  always_comb begin
    g  = a_sh[3:0] & b_sh[3:0];
    p  = a_sh[3:0] ^ b_sh[3:0];
    c1 = g[0] | (p[0] & carry);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & carry);
    s4 = p ^ {c3, c2, c1, carry};
  end

  // New nibbles enter at the MSB end so the LSB nibble lands at the bottom after NIB shifts.
  if (WIDTH == 4) begin : g_single_nibble
    assign sum_next = s4;
  end else begin : g_multi_nibble
    assign sum_next = {s4, sum_sh[WIDTH-1:4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      nib_cnt <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry   <= bus.cin;
            nib_cnt <= '0;
            sum_sh  <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          carry  <= c4;
          if (nib_cnt == LAST) begin
            cout_r <= c4;
            ovf_r  <= c3 ^ c4;
            state  <= DONE;
          end else begin
            nib_cnt <= nib_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_sh;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.busy      = busy_r;
endmodule
